matrix_job_sched: RTL
=====================

MATRIX_JOB_SCHED -- requirements
Module: matrix_job_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 4, job queue entries (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 32, job address width.
REQ-003 SHALL have parameter CNT_W, default 16, completion counter width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have ports job_valid_i input 1 / job_ready_o output 1  job submit handshake.
REQ-007 SHALL have ports job_op_i input 4 and job_src_a_i, job_src_b_i, job_dst_i input ADDR_W  job descriptor.
REQ-008 SHALL have ports acc_valid_o output 1 / acc_ready_i input 1  dispatch handshake to accelerator core.
REQ-009 SHALL have ports acc_op_o output 4 and acc_src_a_o, acc_src_b_o, acc_dst_o output ADDR_W  dispatched descriptor.
REQ-010 SHALL have ports acc_done_i input 1 and acc_err_i input 1  single-cycle job completion pulse and error qualifier.
REQ-011 SHALL have ports flush_i input 1, irq_clr_i input 1  queue flush and sticky-status clear pulses.
REQ-012 SHALL have ports busy_o output 1, pending_o output $clog2(DEPTH+1), done_cnt_o output CNT_W, err_o output 1, irq_o output 1.

Function
REQ-013 SHALL accept a job when job_valid_i && job_ready_o at a rising edge; job_ready_o = (pending_o < DEPTH) && !err_o.
REQ-014 SHALL dispatch jobs in FIFO order; pending_o counts queued, not-yet-dispatched jobs.
REQ-015 SHALL implement FSM IDLE, ISSUE, WAIT: IDLE->ISSUE when queue non-empty and !err_o; ISSUE->WAIT on acc_valid_o && acc_ready_i (pops queue); WAIT->ISSUE on acc_done_i if queue non-empty (post-pop) and no error, else WAIT->IDLE.
REQ-016 SHALL drive acc_valid_o high only in ISSUE, with acc_* equal to queue head, held stable until acc_ready_i.
REQ-017 SHALL, for a job accepted at edge E into an empty queue in IDLE, assert acc_valid_o after edge E+1.
REQ-018 SHALL, on simultaneous accept and pop, leave pending_o unchanged and keep order.
REQ-019 SHALL increment done_cnt_o on every acc_done_i in WAIT, wrapping all-ones to 0; acc_done_i outside WAIT SHALL be ignored.
REQ-020 SHALL set err_o on acc_done_i && acc_err_i in WAIT; while err_o set, no new dispatch and no new accept; queue contents kept.
REQ-021 SHALL set irq_o on each counted completion; irq_o and err_o SHALL be sticky until irq_clr_i; irq_clr_i coinciding with a completion SHALL leave irq_o set.
REQ-022 SHALL, on flush_i, empty the queue (pending_o=0 next cycle) and ignore a same-cycle accept; an ISSUE-state job not yet handshaken SHALL be discarded (FSM->IDLE); a job in WAIT SHALL complete normally.
REQ-023 SHALL drive busy_o = (state != IDLE) || (pending_o != 0).

Reset
REQ-024 SHALL, on rst_n low at a rising edge, enter IDLE, empty queue, and hold acc_valid_o=0, job_ready_o=0 during reset, busy_o=0, pending_o=0, done_cnt_o=0, err_o=0, irq_o=0, acc_* descriptor=0.
REQ-025 SHALL, on reset mid-job, drop in-flight and queued jobs; a later acc_done_i SHALL be ignored (IDLE).

Structure
REQ-026 SHALL place job_t struct (op, src_a, src_b, dst), state enum, and op code constants in package matrix_sched_pkg.
REQ-027 SHALL implement the queue as sub-module job_fifo (DEPTH entries of job_t, push/pop/flush, count).

Verification
REQ-028 Single job op=1, src_a=0x100, src_b=0x200, dst=0x300, acc_ready_i=1, done 5 cycles after dispatch -> acc_valid_o after E+1, done_cnt_o=1, irq_o=1, busy_o=0 after.
REQ-029 Push 5 jobs back-to-back with acc_ready_i=0 -> job_ready_o low on 5th, pending_o=4; release -> dispatch order 1..4 exact.
REQ-030 Completion with acc_err_i=1 while 2 queued -> err_o=1, no further acc_valid_o, pending_o=2; irq_clr_i -> dispatch resumes.
REQ-031 flush_i while in WAIT with 3 queued -> pending_o=0 next cycle, in-flight done still counted, FSM->IDLE.
REQ-032 Preload done_cnt_o to all-ones via 65535 jobs (or force) then one completion -> done_cnt_o=0, irq_o=1.
REQ-033 rst_n low during WAIT, then stray acc_done_i -> all outputs at reset values, done_cnt_o stays 0.

Source files
------------

// File: rtl/matrix_sched_pkg.sv
// Shared types for the matrix job scheduler.
// Descriptors are stored at a fixed maximum address width.
package matrix_sched_pkg;

  localparam int JOB_AW = 64;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_GEMM  = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_XPOSE = 4'd3;

  typedef struct packed {
    logic [3:0]        op;
    logic [JOB_AW-1:0] src_a;
    logic [JOB_AW-1:0] src_b;
    logic [JOB_AW-1:0] dst;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT
  } state_e;

endpackage

// File: rtl/job_fifo.sv
// Circular job queue with occupancy count and flush.
// Push must never be asserted while full.
module job_fifo
  import matrix_sched_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic          i_flush,
  input  job_t          i_din,
  output job_t          o_head,
  output logic [PW-1:0] o_count
);

  localparam int AW = $clog2(DEPTH);

  job_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [PW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/matrix_job_sched.sv
// Matrix accelerator job scheduler: queues descriptors,
// dispatches one at a time and tracks completion status.
module matrix_job_sched
  import matrix_sched_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       job_valid_i,
  output logic                       job_ready_o,
  input  logic [3:0]                 job_op_i,
  input  logic [ADDR_W-1:0]          job_src_a_i,
  input  logic [ADDR_W-1:0]          job_src_b_i,
  input  logic [ADDR_W-1:0]          job_dst_i,
  output logic                       acc_valid_o,
  input  logic                       acc_ready_i,
  output logic [3:0]                 acc_op_o,
  output logic [ADDR_W-1:0]          acc_src_a_o,
  output logic [ADDR_W-1:0]          acc_src_b_o,
  output logic [ADDR_W-1:0]          acc_dst_o,
  input  logic                       acc_done_i,
  input  logic                       acc_err_i,
  input  logic                       flush_i,
  input  logic                       irq_clr_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] pending_o,
  output logic [CNT_W-1:0]           done_cnt_o,
  output logic                       err_o,
  output logic                       irq_o
);

  localparam int PW = $clog2(DEPTH+1);

  state_e           r_state;
  logic [CNT_W-1:0] r_done_cnt;
  logic             r_err;
  logic             r_irq;

  job_t          w_in;
  job_t          w_head;
  logic [PW-1:0] w_count;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_done;
  logic          w_nonempty;
  logic          w_unused;

  assign w_in.op    = job_op_i;
  assign w_in.src_a = JOB_AW'(job_src_a_i);
  assign w_in.src_b = JOB_AW'(job_src_b_i);
  assign w_in.dst   = JOB_AW'(job_dst_i);

  assign w_nonempty  = (w_count != '0);
  assign job_ready_o = rst_n && (w_count < PW'(DEPTH)) && !r_err;
  assign w_push      = job_valid_i && job_ready_o && !flush_i;
  assign w_issue     = rst_n && (r_state == S_ISSUE);
  assign w_pop       = w_issue && acc_ready_i;
  assign w_done      = (r_state == S_WAIT) && acc_done_i;

  job_fifo #(.DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .i_din   (w_in),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Descriptor is only presented while offering a job.
  assign acc_valid_o = w_issue;
  assign acc_op_o    = w_issue ? w_head.op : '0;
  assign acc_src_a_o = w_issue ? ADDR_W'(w_head.src_a) : '0;
  assign acc_src_b_o = w_issue ? ADDR_W'(w_head.src_b) : '0;
  assign acc_dst_o   = w_issue ? ADDR_W'(w_head.dst) : '0;
  assign w_unused    = ^w_head;

  assign busy_o     = (r_state != S_IDLE) || w_nonempty;
  assign pending_o  = w_count;
  assign done_cnt_o = r_done_cnt;
  assign err_o      = r_err;
  assign irq_o      = r_irq;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_done_cnt <= '0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_done) r_done_cnt <= r_done_cnt + CNT_W'(1);
      // A completion wins over a same-cycle clear.
      if (w_done)              r_irq <= 1'b1;
      else if (irq_clr_i)      r_irq <= 1'b0;
      if (w_done && acc_err_i) r_err <= 1'b1;
      else if (irq_clr_i)      r_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_nonempty && !r_err && !flush_i)
            r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (acc_ready_i)  r_state <= S_WAIT;
          else if (flush_i) r_state <= S_IDLE;
        end
        S_WAIT: begin
          if (acc_done_i) begin
            if (w_nonempty && !flush_i && !acc_err_i && !r_err)
              r_state <= S_ISSUE;
            else
              r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
